branch_step_ctrl: RTL and testbench
===================================

# branch_step_ctrl

Control-step sequencer for conditional-branch instructions (brzr, brnz, brpl, brmi) on the single-bus datapath. The main control unit hands it a decoded branch once the fetch steps are done. It then drives the register-file, PC, Y/Z and condition-flip-flop strobes over four control steps (T3–T6). It writes the branch target into PC only when the condition flip-flop reports the condition met.

## Interface
Parameters:
- C2_W, 4, width of the IR condition field.
- N_COND, 4, number of legal condition codes (0..N_COND-1).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; forces IDLE and zeroes every output.
- start  in  1  one-cycle pulse: IR holds a branch instruction; accepted only in IDLE.
- ir_c2  in  C2_W  IR condition field; captured on the start cycle.
- hold  in  1  memory/bus wait; freezes the step counter while high.
- con_met  in  1  condition-flip-flop output.
- gra  out  1  select register Ra from the IR.
- rout  out  1  selected register drives the bus.
- con_in  out  1  load strobe to the condition flip-flop.
- pc_out  out  1  PC drives the bus.
- y_in  out  1  load Y.
- c_out  out  1  sign-extended IR constant drives the bus.
- alu_add  out  1  ALU op = ADD.
- z_in  out  1  load Z.
- zlow_out  out  1  Z[31:0] drives the bus.
- pc_in  out  1  load PC from the bus.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse on the last step.
- taken  out  1  branch taken; valid while done=1, otherwise 0.
- bad_cond  out  1  sticky: a start carried ir_c2 >= N_COND; cleared only by reset.
- step  out  3  current step: 0=IDLE, 3..6=T3..T6.

## Operation
- States: IDLE, T3, T4, T5, T6. No other encodings are reachable. Any illegal state returns to IDLE on the next edge.
- IDLE: all strobes 0. On start=1, capture ir_c2 into c2_r and go to T3. If ir_c2 >= N_COND, set bad_cond and force the branch not-taken.
- T3: gra=1, rout=1, con_in=1. This loads the condition flip-flop from Ra using c2_r.
- T4: pc_out=1, y_in=1.
- T5: c_out=1, alu_add=1, z_in=1. At the end of T5, register take_r = con_met & legal_r.
- T6: zlow_out=1, pc_in=take_r, done=1, taken=take_r. Next state is IDLE.
- The bus has one driver per step: at most one of rout, pc_out, c_out, zlow_out is 1 in any cycle.
- hold=1 in any T-state:
  - state, c2_r and take_r are frozen;
  - all strobes and done are forced to 0, so the step is a bubble;
  - the step re-issues in full in the cycle after hold falls.
- hold has no effect in IDLE.
- start while busy=1 is ignored and is not queued.
- con_met is sampled only at the end of T5 (not held), and is ignored in all other states.

## Timing
- Reset values: every output 0 and step=0. bad_cond=0.
- Reset mid-sequence: IDLE on the next edge. No pc_in or done is issued for the aborted branch.
- Start to first strobe (T3): 1 cycle. Start to done: 4 cycles with no hold. Each hold cycle adds exactly one cycle.
- Start asserted in the same cycle as done: ignored, because the block is not in IDLE. Re-issue is possible from the following cycle.
- Strobes are registered-state decodes (Moore): they depend only on state, hold and take_r, with no combinational path from start or con_met.
- take_r changes only at the end of T5 (not held) and on reset.

## Structure
- Shared control package holds:
  - the state/step encoding constants (IDLE=0, T3..T6=3..6);
  - the condition codes: BR_ZR=0, BR_NZ=1, BR_PL=2, BR_MI=3;
  - N_COND.
- Single module. A sub-module `step_counter` (hold-able 3-bit step register with sync reset and load-on-start) is natural and reusable by the other instruction sequencers.

## Test plan
- Not taken: reset, start with ir_c2=0 and con_met=0 at T5 -> steps 3,4,5,6,0; pc_in=0 in T6; done=1, taken=0 at cycle 4 after start.
- Taken: ir_c2=3, con_met=1 at T5 -> pc_in=1 and zlow_out=1 together in T6; taken=1; busy high for cycles 1–4.
- Hold: hold=1 for 2 cycles during T4 -> pc_out and y_in are 0 while held, then asserted for one cycle; done lands at cycle 6 after start.
- Ignored start: start pulses during T4 and on the done cycle -> no restart; step returns to 0; a start one cycle later begins a new T3.
- Bad condition: ir_c2=9 with con_met=1 -> bad_cond set and stays 1; taken=0 and pc_in=0 in T6.
- Reset mid-op: reset asserted in T5 -> next cycle step=0, all strobes 0, no done pulse, bad_cond=0.

Source files
------------

// File: rtl/branch_step_ctrl_pkg.sv
// Shared encodings for the branch control-step sequencer and sibling instruction sequencers.
// The step encoding is the control-step number, so the step register drives the step port directly.
package branch_step_ctrl_pkg;

  localparam int N_COND = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    BR_ZR = 2'd0,
    BR_NZ = 2'd1,
    BR_PL = 2'd2,
    BR_MI = 2'd3
  } br_cond_t;

endpackage

// File: rtl/branch_step_ctrl_step_counter.sv
// Hold-able control-step register: loads T3 on start from IDLE, advances T3..T6, then returns to IDLE.
// Unused encodings fall back to IDLE on the next edge regardless of hold.
module step_counter
  import branch_step_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_hold,
  output logic [2:0] o_step
);

  state_t r_state;
  state_t w_next;

  // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_T3;
      ST_T3:   if (!i_hold) w_next = ST_T4;
      ST_T4:   if (!i_hold) w_next = ST_T5;
      ST_T5:   if (!i_hold) w_next = ST_T6;
      ST_T6:   if (!i_hold) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  assign o_step = r_state;

endmodule

// File: rtl/branch_step_ctrl.sv
// Conditional-branch sequencer: drives T3..T6 datapath strobes and loads PC with the target
// only when the condition flip-flop reported the condition met at the end of T5.
module branch_step_ctrl #(
  parameter int C2_W   = 4,
  parameter int N_COND = branch_step_ctrl_pkg::N_COND
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [C2_W-1:0] ir_c2,
  input  logic            hold,
  input  logic            con_met,
  output logic            gra,
  output logic            rout,
  output logic            con_in,
  output logic            pc_out,
  output logic            y_in,
  output logic            c_out,
  output logic            alu_add,
  output logic            z_in,
  output logic            zlow_out,
  output logic            pc_in,
  output logic            busy,
  output logic            done,
  output logic            taken,
  output logic            bad_cond,
  output logic [2:0]      step
);

  import branch_step_ctrl_pkg::*;

  logic [2:0]      w_step;
  state_t          w_state;
  logic            w_idle;
  logic            w_legal;
  logic            w_legal_in;
  logic [C2_W-1:0] r_c2;
  logic            r_take;
  logic            r_bad_cond;

  step_counter u_step_counter (
    .i_clk   (clock),
    .i_reset (reset),
    .i_start (start),
    .i_hold  (hold),
    .o_step  (w_step)
  );

  assign w_state    = state_t'(w_step);
  assign w_idle     = (w_state == ST_IDLE);
  assign w_legal_in = (32'(ir_c2) < 32'(N_COND));
  assign w_legal    = (32'(r_c2) < 32'(N_COND));

  // An illegal condition code can never produce a taken branch, whatever the flip-flop says.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_c2       <= '0;
      r_take     <= 1'b0;
      r_bad_cond <= 1'b0;
    end else begin
      if (w_idle && start) begin
        r_c2 <= ir_c2;
        if (!w_legal_in) r_bad_cond <= 1'b1;
      end
      if ((w_state == ST_T5) && !hold) r_take <= con_met & w_legal;
    end
  end

  always_comb begin
    gra      = 1'b0;
    rout     = 1'b0;
    con_in   = 1'b0;
    pc_out   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    done     = 1'b0;
    taken    = 1'b0;
    busy     = 1'b0;
    // A held step is a bubble: busy stays up but nothing strobes.
    case (w_state)
      ST_T3: begin
        busy = 1'b1;
        if (!hold) begin
          gra    = 1'b1;
          rout   = 1'b1;
          con_in = 1'b1;
        end
      end
      ST_T4: begin
        busy = 1'b1;
        if (!hold) begin
          pc_out = 1'b1;
          y_in   = 1'b1;
        end
      end
      ST_T5: begin
        busy = 1'b1;
        if (!hold) begin
          c_out   = 1'b1;
          alu_add = 1'b1;
          z_in    = 1'b1;
        end
      end
      ST_T6: begin
        busy = 1'b1;
        if (!hold) begin
          zlow_out = 1'b1;
          pc_in    = r_take;
          done     = 1'b1;
          taken    = r_take;
        end
      end
      default: ;
    endcase
  end

  assign bad_cond = r_bad_cond;
  assign step     = w_step;

endmodule

// File: tb/tb_branch_step_ctrl.sv
// Directed bench for branch_step_ctrl: every cycle compares the full output word
// {step, strobes, busy, done, taken, bad_cond} against a hand-built expected word.
module tb_branch_step_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] ir_c2;
  logic       hold;
  logic       con_met;
  logic       gra, rout, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in;
  logic       busy, done, taken, bad_cond;
  logic [2:0] step;

  int n_tests = 0;
  int n_fail  = 0;

  branch_step_ctrl #(.C2_W(4), .N_COND(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .ir_c2    (ir_c2),
    .hold     (hold),
    .con_met  (con_met),
    .gra      (gra),
    .rout     (rout),
    .con_in   (con_in),
    .pc_out   (pc_out),
    .y_in     (y_in),
    .c_out    (c_out),
    .alu_add  (alu_add),
    .z_in     (z_in),
    .zlow_out (zlow_out),
    .pc_in    (pc_in),
    .busy     (busy),
    .done     (done),
    .taken    (taken),
    .bad_cond (bad_cond),
    .step     (step)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [16:0] obs;
  assign obs = {step, gra, rout, con_in, pc_out, y_in, c_out, alu_add, z_in,
                zlow_out, pc_in, busy, done, taken, bad_cond};

  localparam logic [16:0] M_BAD   = 17'h00001;
  localparam logic [16:0] M_TAKEN = 17'h00002;
  localparam logic [16:0] M_DONE  = 17'h00004;
  localparam logic [16:0] M_BUSY  = 17'h00008;
  localparam logic [16:0] M_PCIN  = 17'h00010;
  localparam logic [16:0] M_ZLOW  = 17'h00020;
  localparam logic [16:0] M_ZIN   = 17'h00040;
  localparam logic [16:0] M_ALU   = 17'h00080;
  localparam logic [16:0] M_COUT  = 17'h00100;
  localparam logic [16:0] M_YIN   = 17'h00200;
  localparam logic [16:0] M_PCOUT = 17'h00400;
  localparam logic [16:0] M_CONIN = 17'h00800;
  localparam logic [16:0] M_ROUT  = 17'h01000;
  localparam logic [16:0] M_GRA   = 17'h02000;
  localparam logic [16:0] S3      = 17'h0C000;
  localparam logic [16:0] S4      = 17'h10000;
  localparam logic [16:0] S5      = 17'h14000;
  localparam logic [16:0] S6      = 17'h18000;

  localparam logic [16:0] E_IDLE = 17'h0;
  localparam logic [16:0] E_T3   = S3 | M_GRA | M_ROUT | M_CONIN | M_BUSY;
  localparam logic [16:0] E_T4   = S4 | M_PCOUT | M_YIN | M_BUSY;
  localparam logic [16:0] E_T5   = S5 | M_COUT | M_ALU | M_ZIN | M_BUSY;
  localparam logic [16:0] E_T6N  = S6 | M_ZLOW | M_BUSY | M_DONE;
  localparam logic [16:0] E_T6T  = S6 | M_ZLOW | M_PCIN | M_BUSY | M_DONE | M_TAKEN;
  localparam logic [16:0] E_H4   = S4 | M_BUSY;
  localparam logic [16:0] E_H5   = S5 | M_BUSY;
  localparam logic [16:0] E_H6   = S6 | M_BUSY;

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Drive this cycle's inputs, compare outputs mid-cycle, then advance one clock.
  task automatic run_cycle(input logic s, input logic h, input logic cm,
                           input string tag, input logic [16:0] exp);
    start   = s;
    hold    = h;
    con_met = cm;
    #1;
    check(tag, obs, exp);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ir_c2 = 4'd0; hold = 1'b0; con_met = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", obs, E_IDLE);
    reset = 1'b0;

    // Not taken: con_met high everywhere except at the T5 sample point.
    ir_c2 = 4'd0;
    run_cycle(1, 0, 0, "nt_idle", E_IDLE);
    ir_c2 = 4'd0;
    run_cycle(0, 0, 1, "nt_t3",   E_T3);
    run_cycle(0, 0, 1, "nt_t4",   E_T4);
    run_cycle(0, 0, 0, "nt_t5",   E_T5);
    run_cycle(0, 0, 1, "nt_t6",   E_T6N);
    run_cycle(0, 0, 0, "nt_end",  E_IDLE);

    // Taken; the IR field changes after capture and must not matter.
    ir_c2 = 4'd3;
    run_cycle(1, 0, 0, "tk_idle", E_IDLE);
    ir_c2 = 4'hF;
    run_cycle(0, 0, 0, "tk_t3",   E_T3);
    run_cycle(0, 0, 0, "tk_t4",   E_T4);
    run_cycle(0, 0, 1, "tk_t5",   E_T5);
    run_cycle(0, 0, 0, "tk_t6",   E_T6T);
    run_cycle(0, 0, 0, "tk_end",  E_IDLE);

    // Two hold cycles in T4: done lands six cycles after start.
    ir_c2 = 4'd1;
    run_cycle(1, 0, 0, "h4_idle", E_IDLE);
    run_cycle(0, 0, 0, "h4_t3",   E_T3);
    run_cycle(0, 1, 0, "h4_hld1", E_H4);
    run_cycle(0, 1, 0, "h4_hld2", E_H4);
    run_cycle(0, 0, 0, "h4_t4",   E_T4);
    run_cycle(0, 0, 1, "h4_t5",   E_T5);
    run_cycle(0, 0, 0, "h4_t6",   E_T6T);
    run_cycle(0, 0, 0, "h4_end",  E_IDLE);

    // Hold in T5 with con_met high: the held cycle must not sample it. Hold in T6 bubbles done.
    ir_c2 = 4'd2;
    run_cycle(1, 0, 0, "h5_idle", E_IDLE);
    run_cycle(0, 0, 0, "h5_t3",   E_T3);
    run_cycle(0, 0, 0, "h5_t4",   E_T4);
    run_cycle(0, 1, 1, "h5_hld",  E_H5);
    run_cycle(0, 0, 0, "h5_t5",   E_T5);
    run_cycle(0, 1, 0, "h5_hld6", E_H6);
    run_cycle(0, 0, 0, "h5_t6",   E_T6N);
    run_cycle(0, 0, 0, "h5_end",  E_IDLE);

    // Starts in T4 and on the done cycle are ignored; hold in IDLE does not block a start.
    ir_c2 = 4'd0;
    run_cycle(1, 0, 0, "ig_idle", E_IDLE);
    run_cycle(0, 0, 0, "ig_t3",   E_T3);
    run_cycle(1, 0, 0, "ig_t4",   E_T4);
    run_cycle(0, 0, 0, "ig_t5",   E_T5);
    run_cycle(1, 0, 0, "ig_t6",   E_T6N);
    run_cycle(1, 1, 0, "ig_back", E_IDLE);
    run_cycle(0, 0, 0, "ig_re3",  E_T3);
    run_cycle(0, 0, 0, "ig_re4",  E_T4);
    run_cycle(0, 0, 0, "ig_re5",  E_T5);
    run_cycle(0, 0, 0, "ig_re6",  E_T6N);
    run_cycle(0, 0, 0, "ig_end",  E_IDLE);

    // Illegal condition code: sticky bad_cond, forced not-taken even with con_met high.
    ir_c2 = 4'd9;
    run_cycle(1, 0, 1, "bc_idle", E_IDLE);
    ir_c2 = 4'd0;
    run_cycle(0, 0, 1, "bc_t3",   E_T3 | M_BAD);
    run_cycle(0, 0, 1, "bc_t4",   E_T4 | M_BAD);
    run_cycle(0, 0, 1, "bc_t5",   E_T5 | M_BAD);
    run_cycle(0, 0, 1, "bc_t6",   E_T6N | M_BAD);
    run_cycle(0, 0, 0, "bc_end",  E_IDLE | M_BAD);

    // A following legal branch is taken again; bad_cond stays set.
    ir_c2 = 4'd3;
    run_cycle(1, 0, 0, "bl_idle", E_IDLE | M_BAD);
    run_cycle(0, 0, 0, "bl_t3",   E_T3 | M_BAD);
    run_cycle(0, 0, 0, "bl_t4",   E_T4 | M_BAD);
    run_cycle(0, 0, 1, "bl_t5",   E_T5 | M_BAD);
    run_cycle(0, 0, 0, "bl_t6",   E_T6T | M_BAD);

    // Reset in T5: IDLE next cycle, no done, bad_cond cleared, take state cleared.
    ir_c2 = 4'd1;
    run_cycle(1, 0, 0, "rs_idle", E_IDLE | M_BAD);
    run_cycle(0, 0, 0, "rs_t3",   E_T3 | M_BAD);
    run_cycle(0, 0, 0, "rs_t4",   E_T4 | M_BAD);
    reset = 1'b1;
    run_cycle(0, 0, 1, "rs_t5",   E_T5 | M_BAD);
    reset = 1'b0;
    run_cycle(0, 0, 0, "rs_aft1", E_IDLE);
    run_cycle(0, 0, 0, "rs_aft2", E_IDLE);

    // After reset a fresh branch with con_met low must not be taken.
    ir_c2 = 4'd1;
    run_cycle(1, 0, 0, "pr_idle", E_IDLE);
    run_cycle(0, 0, 0, "pr_t3",   E_T3);
    run_cycle(0, 0, 0, "pr_t4",   E_T4);
    run_cycle(0, 0, 0, "pr_t5",   E_T5);
    run_cycle(0, 0, 0, "pr_t6",   E_T6N);
    run_cycle(0, 0, 0, "pr_end",  E_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
